// File: rtl/pe_ws_mac.sv
// Weight-stationary MAC processing element: streams activations, holds a weight, adds into an upstream or local partial sum.
// Latency 1 cycle in pass-through; local accumulation drains one cycle after acc_done. No backpressure: valid_in is always accepted.
module pe_ws_mac #(
    parameter int DW     = 8,
    parameter int PW     = 16,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          w_load,
    input  logic [DW-1:0] w_in,
    output logic [DW-1:0] w_out,
    input  logic          valid_in,
    input  logic [DW-1:0] element_in,
    input  logic [PW-1:0] pSum_in,
    input  logic          acc_start,
    input  logic          acc_done,
    output logic [DW-1:0] element_out,
    output logic          valid_out,
    output logic [PW-1:0] pSum_out,
    output logic          pSum_valid_out,
    output logic          ovf_sticky
);

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0]   weight;
    logic [PW-1:0]   acc;
    logic [2*DW-1:0] e_ext, w_ext, prod_raw;
    logic [PW-1:0]   prod_ext;
    logic [PW:0]     pass_sum, acc_sum;

    assign w_out = weight;

    // Operands are widened to the full product width first so the low 2*DW bits are exact in either mode.
    always_comb begin
        if (SIGNED != 0) begin
            e_ext = {{DW{element_in[DW-1]}}, element_in};
            w_ext = {{DW{weight[DW-1]}}, weight};
        end else begin
            e_ext = {{DW{1'b0}}, element_in};
            w_ext = {{DW{1'b0}}, weight};
        end
        prod_raw = e_ext * w_ext;
        if (SIGNED != 0) begin
            prod_ext = PW'($signed(prod_raw));
        end else begin
            prod_ext = PW'(prod_raw);
        end
    end

    // Returns {overflow, result}; the sum is formed one bit wider than PW to detect out-of-range.
    function automatic logic [PW:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW:0]   s;
        logic          ovf;
        logic [PW-1:0] r;
        if (SIGNED != 0) begin
            s   = {a[PW-1], a} + {b[PW-1], b};
            ovf = s[PW] ^ s[PW-1];
        end else begin
            s   = {1'b0, a} + {1'b0, b};
            ovf = s[PW];
        end
        r = s[PW-1:0];
        if (ovf && (SAT != 0)) begin
            if (SIGNED != 0) begin
                r = s[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
            end else begin
                r = '1;
            end
        end
        return {ovf, r};
    endfunction

    assign pass_sum = sat_add(prod_ext, pSum_in);
    assign acc_sum  = sat_add(acc, prod_ext);

    always_comb begin
        state_nxt = state;
        case (state)
            PASS:    if (acc_start) state_nxt = ACC;
            ACC:     if (acc_done) state_nxt = DRAIN;
            DRAIN:   state_nxt = PASS;
            default: state_nxt = PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state          <= PASS;
            weight         <= '0;
            acc            <= '0;
            element_out    <= '0;
            valid_out      <= 1'b0;
            pSum_out       <= '0;
            pSum_valid_out <= 1'b0;
            ovf_sticky     <= 1'b0;
        end else begin
            state     <= state_nxt;
            valid_out <= valid_in;
            if (w_load) weight <= w_in;
            if (valid_in) element_out <= element_in;

            case (state)
                PASS: begin
                    pSum_valid_out <= valid_in;
                    if (valid_in) begin
                        pSum_out <= pass_sum[PW-1:0];
                        if (pass_sum[PW]) ovf_sticky <= 1'b1;
                    end
                    if (acc_start) acc <= '0;
                end
                ACC: begin
                    pSum_valid_out <= 1'b0;
                    if (valid_in) begin
                        acc <= acc_sum[PW-1:0];
                        if (acc_sum[PW]) ovf_sticky <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Samples arriving during the drain cycle are not summed.
                    pSum_out       <= acc;
                    pSum_valid_out <= 1'b1;
                    acc            <= '0;
                end
                default: pSum_valid_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_ws_mac.sv
// Randomized and directed check of pe_ws_mac: four instances (saturating, wrapping, signed, chained) against an arithmetic reference model.
module tb_pe_ws_mac;

    logic        clk = 1'b0;
    logic        clear, w_load, valid_in, acc_start, acc_done;
    logic [7:0]  w_in, element_in;
    logic [15:0] pSum_in;

    logic [3:0][7:0]  wo, eo;
    logic [3:0][15:0] ps;
    logic [3:0]       vo, pv, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_ws_mac #(.DW(8), .PW(16), .SIGNED(0), .SAT(1)) u_sat (
        .clk(clk), .clear(clear), .w_load(w_load), .w_in(w_in), .w_out(wo[0]),
        .valid_in(valid_in), .element_in(element_in), .pSum_in(pSum_in),
        .acc_start(acc_start), .acc_done(acc_done), .element_out(eo[0]),
        .valid_out(vo[0]), .pSum_out(ps[0]), .pSum_valid_out(pv[0]), .ovf_sticky(ovf[0]));

    pe_ws_mac #(.DW(8), .PW(16), .SIGNED(0), .SAT(0)) u_wrap (
        .clk(clk), .clear(clear), .w_load(w_load), .w_in(w_in), .w_out(wo[1]),
        .valid_in(valid_in), .element_in(element_in), .pSum_in(pSum_in),
        .acc_start(acc_start), .acc_done(acc_done), .element_out(eo[1]),
        .valid_out(vo[1]), .pSum_out(ps[1]), .pSum_valid_out(pv[1]), .ovf_sticky(ovf[1]));

    pe_ws_mac #(.DW(8), .PW(16), .SIGNED(1), .SAT(1)) u_sgn (
        .clk(clk), .clear(clear), .w_load(w_load), .w_in(w_in), .w_out(wo[2]),
        .valid_in(valid_in), .element_in(element_in), .pSum_in(pSum_in),
        .acc_start(acc_start), .acc_done(acc_done), .element_out(eo[2]),
        .valid_out(vo[2]), .pSum_out(ps[2]), .pSum_valid_out(pv[2]), .ovf_sticky(ovf[2]));

    pe_ws_mac #(.DW(8), .PW(16), .SIGNED(0), .SAT(1)) u_chain (
        .clk(clk), .clear(clear), .w_load(w_load), .w_in(wo[0]), .w_out(wo[3]),
        .valid_in(valid_in), .element_in(element_in), .pSum_in(pSum_in),
        .acc_start(acc_start), .acc_done(acc_done), .element_out(eo[3]),
        .valid_out(vo[3]), .pSum_out(ps[3]), .pSum_valid_out(pv[3]), .ovf_sticky(ovf[3]));

    // Reference state per instance
    logic [7:0]  m_w[4], m_eo[4];
    logic [15:0] m_ps[4];
    longint      m_acc[4];
    logic        m_vo[4], m_pv[4], m_ovf[4], m_accum[4], m_drain[4];

    function automatic bit is_sg(int k);
        return k == 2;
    endfunction

    function automatic bit is_sat(int k);
        return k != 1;
    endfunction

    function automatic longint to_val(logic [15:0] x, int bits, bit sg);
        longint u = longint'(x) & ((longint'(1) << bits) - 1);
        if (sg && u >= (longint'(1) << (bits - 1))) u = u - (longint'(1) << bits);
        return u;
    endfunction

    task automatic fit(input int k, input longint s, output longint r);
        longint lo = is_sg(k) ? -32768 : 0;
        longint hi = is_sg(k) ? 32767 : 65535;
        r = s;
        if (s < lo || s > hi) begin
            m_ovf[k] = 1'b1;
            if (is_sat(k)) r = (s > hi) ? hi : lo;
            else r = to_val(16'(s), 16, is_sg(k));
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0] wi = (k == 3) ? m_w[0] : w_in;
        longint prod, r;
        if (clear) begin
            m_w[k] = 0; m_eo[k] = 0; m_ps[k] = 0; m_acc[k] = 0;
            m_vo[k] = 0; m_pv[k] = 0; m_ovf[k] = 0; m_accum[k] = 0; m_drain[k] = 0;
            return;
        end
        prod = to_val(16'(element_in), 8, is_sg(k)) * to_val(16'(m_w[k]), 8, is_sg(k));
        if (m_drain[k]) begin
            m_ps[k] = 16'(m_acc[k]);
            m_pv[k] = 1'b1;
            m_acc[k] = 0;
            m_drain[k] = 1'b0;
        end else if (m_accum[k]) begin
            m_pv[k] = 1'b0;
            if (valid_in) begin
                fit(k, m_acc[k] + prod, r);
                m_acc[k] = r;
            end
            if (acc_done) begin
                m_accum[k] = 1'b0;
                m_drain[k] = 1'b1;
            end
        end else begin
            m_pv[k] = valid_in;
            if (valid_in) begin
                fit(k, prod + to_val(pSum_in, 16, is_sg(k)), r);
                m_ps[k] = 16'(r);
            end
            if (acc_start) begin
                m_acc[k] = 0;
                m_accum[k] = 1'b1;
            end
        end
        m_vo[k] = valid_in;
        if (valid_in) m_eo[k] = element_in;
        if (w_load) m_w[k] = wi;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("psum%0d", k), 32'(ps[k]), 32'(m_ps[k]));
            chk($sformatf("pvld%0d", k), 32'(pv[k]), 32'(m_pv[k]));
            chk($sformatf("eout%0d", k), 32'(eo[k]), 32'(m_eo[k]));
            chk($sformatf("vout%0d", k), 32'(vo[k]), 32'(m_vo[k]));
            chk($sformatf("wout%0d", k), 32'(wo[k]), 32'(m_w[k]));
            chk($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
        end
    endtask

    task automatic cyc(input logic c, input logic wl, input logic [7:0] wi, input logic v,
                       input logic [7:0] e, input logic [15:0] p, input logic st, input logic dn);
        clear = c; w_load = wl; w_in = wi; valid_in = v;
        element_in = e; pSum_in = p; acc_start = st; acc_done = dn;
        @(posedge clk);
        model_step(3);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        compare_all();
    endtask

    initial begin
        clear = 1; w_load = 0; w_in = 0; valid_in = 0;
        element_in = 0; pSum_in = 0; acc_start = 0; acc_done = 0;
        for (int k = 0; k < 4; k++) begin
            m_w[k] = 'x; m_eo[k] = 'x; m_ps[k] = 'x; m_acc[k] = 0;
            m_vo[k] = 'x; m_pv[k] = 'x; m_ovf[k] = 'x; m_accum[k] = 0; m_drain[k] = 0;
        end
        #2;

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_psum", 32'(ps[0]), 0);
        chk("rst_pvld", 32'(pv[0]), 0);
        chk("rst_ovf", 32'(ovf[0]), 0);

        // Weight chain
        cyc(0, 1, 7, 0, 0, 0, 0, 0);
        cyc(0, 1, 9, 0, 0, 0, 0, 0);
        chk("chain_w0", 32'(wo[0]), 9);
        chk("chain_w1", 32'(wo[3]), 7);

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 5, 10, 0, 0);
        chk("basic_psum", 32'(ps[0]), 25);
        chk("basic_pvld", 32'(pv[0]), 1);
        chk("basic_eout", 32'(eo[0]), 5);

        // 255*255 + 1000 = 66025: saturates to 65535, wraps to 489; +975 wraps to 464
        cyc(0, 1, 255, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 255, 1000, 0, 0);
        chk("sat_psum", 32'(ps[0]), 65535);
        chk("sat_ovf", 32'(ovf[0]), 1);
        chk("wrap_psum", 32'(ps[1]), 489);
        cyc(0, 0, 0, 1, 255, 975, 0, 0);
        chk("wrap_psum2", 32'(ps[1]), 464);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_hold", 32'(ovf[0]), 1);
        chk("hold_pvld", 32'(pv[0]), 0);
        chk("hold_psum", 32'(ps[0]), 65535);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_clr", 32'(ovf[0]), 0);

        cyc(0, 1, 8'hFE, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 4, 3, 0, 0);
        chk("signed_psum", 32'(ps[2]), 32'h0000FFFB);

        // Local accumulation: weight 2, elements 1,2,3
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 100, 0, 0);
        chk("acc_pvld1", 32'(pv[0]), 0);
        cyc(0, 0, 0, 1, 2, 100, 0, 0);
        chk("acc_pvld2", 32'(pv[0]), 0);
        cyc(0, 0, 0, 1, 3, 100, 0, 1);
        chk("acc_pvld3", 32'(pv[0]), 0);
        cyc(0, 0, 0, 1, 9, 100, 0, 0);
        chk("drain_pvld", 32'(pv[0]), 1);
        chk("drain_psum", 32'(ps[0]), 12);
        chk("drain_eout", 32'(eo[0]), 9);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_drain_pvld", 32'(pv[0]), 0);

        // Clear in the middle of accumulation
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 0, 0, 0);
        cyc(1, 1, 5, 1, 3, 7, 1, 1);
        chk("clr_psum", 32'(ps[0]), 0);
        chk("clr_eout", 32'(eo[0]), 0);
        chk("clr_vout", 32'(vo[0]), 0);
        chk("clr_wout", 32'(wo[0]), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("clr_nodrain", 32'(pv[0]), 0);
        cyc(0, 1, 2, 1, 5, 1, 0, 0);
        chk("clr_pass1", 32'(ps[0]), 1);
        cyc(0, 0, 0, 1, 5, 1, 0, 0);
        chk("clr_pass2", 32'(ps[0]), 11);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 97) == 0, ($urandom % 4) == 0, 8'($urandom),
                ($urandom % 3) != 0, 8'($urandom), 16'($urandom),
                ($urandom % 8) == 0, ($urandom % 6) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
